// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core: ALU control codes and
// the state encoding of the sequential multiplier controller.
package mips_pkg;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b100;
    localparam logic [2:0] SLT = 3'b110;
    localparam logic [2:0] MUL = 3'b101;

    localparam logic [1:0] MS_IDLE = 2'b00;
    localparam logic [1:0] MS_RUN  = 2'b01;
    localparam logic [1:0] MS_DONE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = MS_IDLE,
        ST_RUN  = MS_RUN,
        ST_DONE = MS_DONE
    } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// Handshake and operand/result bundle between the control unit (master)
// and the multi-cycle multiplier (slave).
interface mul_sequencer_if #(
    parameter int WIDTH = 32
);
    import mips_pkg::*;

    logic             Start;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Stall;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;

    modport master (
        output Start, SrcA, SrcB,
        input  Stall, Busy, Done, Result, ResultHi
    );

    modport slave (
        input  Start, SrcA, SrcB,
        output Stall, Busy, Done, Result, ResultHi
    );

endinterface

// File: rtl/mul_datapath.sv
// Shift-add multiplier registers: multiplicand shifts left, multiplier shifts
// right, and the product accumulates whenever the multiplier LSB is set.
module mul_datapath
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   srca,
    input  logic [WIDTH-1:0]   srcb,
    output logic [2*WIDTH-1:0] prod
);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] prod_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            prod_reg   <= '0;
        end else if (load) begin
            mcand_reg  <= {{WIDTH{1'b0}}, srca};
            mplier_reg <= srcb;
            prod_reg   <= '0;
        end else if (step) begin
            // Sum wraps at 2*WIDTH bits; the full product always fits.
            if (mplier_reg[0]) begin
                prod_reg <= prod_reg + mcand_reg;
            end
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
        end
    end

    assign prod = prod_reg;

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle mul controller: stalls the core for WIDTH+1 cycles and returns
// the product with a one-cycle Done strobe.
module mul_sequencer
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    mul_sequencer_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               busy_reg;
    logic               done_reg;
    logic               load;
    logic               step;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            busy_reg  <= (state_next == ST_RUN);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;
        step       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (bus.Start) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                step     = 1'b1;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH - 1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .step    (step),
        .srca    (bus.SrcA),
        .srcb    (bus.SrcB),
        .prod    (prod)
    );

    // Stall drops in DONE so the stalled mul retires that cycle with Result.
    assign bus.Stall    = ((state_reg == ST_IDLE) && bus.Start) || (state_reg == ST_RUN);
    assign bus.Busy     = busy_reg;
    assign bus.Done     = done_reg;
    assign bus.Result   = prod[WIDTH-1:0];
    assign bus.ResultHi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: expected products are queued when an
// operation starts and compared when Done is observed.
module tb_mul_sequencer;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] last_prod = '0;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = {{W{1'b0}}, a};
        eb = {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Starts one multiply and waits (bounded) for Done; no comparisons here.
    task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] expv,
                          output int lat, output logic [2*W-1:0] got, output bit seen);
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.SrcA  = a;
        bus.SrcB  = b;
        exp_q.push_back(expv);
        seen = 1'b0;
        lat  = -1;
        got  = '0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (bus.Done) begin
                seen = 1'b1;
                lat  = cyc;
                got  = {bus.ResultHi, bus.Result};
                break;
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
            bus.SrcA  = $urandom;
            bus.SrcB  = $urandom;
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {bus.Stall, bus.Busy, bus.Done});
        end
        checks++;
        if ({bus.ResultHi, bus.Result} !== 64'd0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 0", {bus.ResultHi, bus.Result});
        end
        bus.Start = 1'b1;
        #1;
        checks++;
        if (bus.Stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_follows_start: got %b expected 1", bus.Stall);
        end
        bus.Start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_basic;
        logic [2:0] exp_sig;
        logic [2*W-1:0] expv;
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.SrcA  = 32'd3;
        bus.SrcB  = 32'd5;
        exp_q.push_back(64'd15);
        for (int cyc = 0; cyc <= 34; cyc++) begin
            @(negedge clk);
            exp_sig = {cyc <= 32, (cyc >= 1) && (cyc <= 32), cyc == 33};
            checks++;
            if ({bus.Stall, bus.Busy, bus.Done} !== exp_sig) begin
                errors++;
                $display("FAIL basic_timing cycle %0d: stall/busy/done got %b expected %b",
                         cyc, {bus.Stall, bus.Busy, bus.Done}, exp_sig);
            end
            if (cyc == 33) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if ({bus.ResultHi, bus.Result} !== expv) begin
                    errors++;
                    $display("FAIL basic_result: got %h expected %h", {bus.ResultHi, bus.Result}, expv);
                end
                last_prod = expv;
                $display("op 3*5: hi=%h lo=%h at cycle %0d", bus.ResultHi, bus.Result, cyc);
            end
            @(posedge clk); #1;
            bus.Start = 1'b0;
        end
    endtask

    task automatic test_products;
        logic [W-1:0]   ta[6];
        logic [W-1:0]   tb[6];
        logic [2*W-1:0] te[6];
        logic [2*W-1:0] got;
        logic [2*W-1:0] expv;
        int lat;
        bit seen;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'd2;          te[0] = 64'h0000_0001_FFFF_FFFE;
        ta[1] = 32'hFFFF_FFFF; tb[1] = 32'hFFFF_FFFF;  te[1] = 64'hFFFF_FFFE_0000_0001;
        ta[2] = 32'h0000_1234; tb[2] = 32'd0;          te[2] = 64'd0;
        ta[3] = 32'h8000_0000; tb[3] = 32'h8000_0000;  te[3] = 64'h4000_0000_0000_0000;
        for (int i = 4; i < 6; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
            te[i] = model(ta[i], tb[i]);
        end
        for (int i = 0; i < 6; i++) begin
            do_mul(ta[i], tb[i], te[i], lat, got, seen);
            checks++;
            if (!seen || lat != 33) begin
                errors++;
                $display("FAIL product_latency[%0d]: got %0d expected 33", i, lat);
            end
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL product[%0d]: got %h expected %h", i, got, expv);
            end
            last_prod = expv;
            $display("op %h*%h: product=%h latency=%0d", ta[i], tb[i], got, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic exp_done;
        logic [2*W-1:0] expv;
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.SrcA  = 32'd9;
        bus.SrcB  = 32'd11;
        exp_q.push_back(64'd99);
        for (int cyc = 0; cyc <= 68; cyc++) begin
            @(negedge clk);
            exp_done = (cyc == 33) || (cyc == 67);
            checks++;
            if (bus.Done !== exp_done) begin
                errors++;
                $display("FAIL b2b_done cycle %0d: got %b expected %b", cyc, bus.Done, exp_done);
            end
            if (cyc == 34) begin
                checks++;
                if ({bus.Stall, bus.Busy} !== 2'b10) begin
                    errors++;
                    $display("FAIL b2b_idle_restart: stall/busy got %b expected 10", {bus.Stall, bus.Busy});
                end
            end
            if (bus.Done) begin
                expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if ({bus.ResultHi, bus.Result} !== expv) begin
                    errors++;
                    $display("FAIL b2b_result cycle %0d: got %h expected %h", cyc, {bus.ResultHi, bus.Result}, expv);
                end
                last_prod = expv;
                $display("b2b op done at cycle %0d: product=%h", cyc, {bus.ResultHi, bus.Result});
            end
            @(posedge clk); #1;
            if (cyc + 1 == 34) begin
                bus.SrcA = 32'd13;
                bus.SrcB = 32'd17;
                exp_q.push_back(64'd221);
            end else begin
                bus.SrcA = $urandom;
                bus.SrcB = $urandom;
            end
            if (cyc >= 67) bus.Start = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_queue_drained: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_async_reset;
        logic [2*W-1:0] got;
        logic [2*W-1:0] expv;
        int lat;
        bit seen;
        @(posedge clk); #1;
        bus.Start = 1'b1;
        bus.SrcA  = 32'h0000_1234;
        bus.SrcB  = 32'h0000_5678;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.Start = 1'b0;
        end
        checks++;
        if (bus.Busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_busy_before: got %b expected 1", bus.Busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000) begin
            errors++;
            $display("FAIL areset_flags: got %b expected 000", {bus.Stall, bus.Busy, bus.Done});
        end
        checks++;
        if ({bus.ResultHi, bus.Result} !== 64'd0) begin
            errors++;
            $display("FAIL areset_result: got %h expected 0", {bus.ResultHi, bus.Result});
        end
        bus.Start = 1'b1;
        #1;
        checks++;
        if (bus.Stall !== 1'b1) begin
            errors++;
            $display("FAIL areset_stall_follows_start: got %b expected 1", bus.Stall);
        end
        bus.Start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_mul(32'd7, 32'd6, 64'd42, lat, got, seen);
        checks++;
        if (!seen || lat != 33) begin
            errors++;
            $display("FAIL areset_restart_latency: got %0d expected 33", lat);
        end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL areset_restart_result: got %h expected %h", got, expv);
        end
        last_prod = expv;
        $display("op 7*6 after reset: product=%h latency=%0d", got, lat);
    endtask

    task automatic test_idle_hold;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.SrcA = $urandom;
            bus.SrcB = $urandom;
            @(negedge clk);
            checks++;
            if ({bus.Stall, bus.Busy, bus.Done} !== 3'b000) begin
                errors++;
                $display("FAIL idle_flags cycle %0d: got %b expected 000", cyc, {bus.Stall, bus.Busy, bus.Done});
            end
            checks++;
            if ({bus.ResultHi, bus.Result} !== last_prod) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got %h expected %h", cyc, {bus.ResultHi, bus.Result}, last_prod);
            end
            @(posedge clk); #1;
        end
        $display("idle: 40 cycles held product=%h", last_prod);
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.SrcA  = '0;
        bus.SrcB  = '0;
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_async_reset();
        test_idle_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
